led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
Downstream output stage for the LED pattern sequencer. Takes the sequencer's per-LED on/off pattern and drives the physical LED pins through per-channel PWM, so each LED fades in and out instead of switching hard. Each channel ramps its brightness level one step per fade tick toward its target and saturates at the ends. The block sits between the sequencer outputs and the board LED pins.

Parameters:
NUM_CH, 3, number of LED channels
PWM_BITS, 8, width of the PWM counter and brightness level; MAX = 2^PWM_BITS-1
STEP_DIV, 196000, clk cycles per brightness step; at 100 MHz a full 0..255 fade takes about 0.5 s

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
en  in  1  1 = run; 0 = freeze levels and blank outputs
led_in  in  NUM_CH  target pattern from the sequencer; bit i = LEDi target on
led_out  out  NUM_CH  PWM-driven LED pins, registered
busy  out  1  1 while any channel is RISING or FALLING, registered

Behaviour:
- Reset: rst=0 forces these values immediately, with no clock needed:
  - prescaler = 0, pwm_cnt = 0, led_in_q = 0
  - every level = 0, every state = OFF
  - led_out = 0, busy = 0
- Input stage: led_in_q <= led_in on every clk. All decisions use led_in_q only.
- Prescaler:
  - When en=1, counts 0..STEP_DIV-1 and wraps to 0.
  - step_tick is high for exactly one cycle when the count equals STEP_DIV-1.
  - When en=0, the prescaler is held at 0.
- PWM counter pwm_cnt:
  - Width PWM_BITS. Increments every clk when en=1 and wraps from MAX to 0.
  - Held at 0 when en=0.
- Per-channel level update (only on step_tick with en=1):
  - led_in_q[i]=1 and level<MAX: level+1.
  - led_in_q[i]=0 and level>0: level-1.
  - Otherwise unchanged. Level saturates at both ends and never wraps.
- Per-channel state machine:
  - States: OFF, RISING, ON, FALLING.
  - Transitions are evaluated every cycle from led_in_q and the post-update level.
  - OFF -> RISING when led_in_q=1.
  - RISING -> ON when level reaches MAX.
  - RISING -> FALLING when led_in_q=0 (reversal mid-ramp, level continues from its current value).
  - ON -> FALLING when led_in_q=0.
  - FALLING -> OFF when level reaches 0.
  - FALLING -> RISING when led_in_q=1.
- Output: led_out[i] <= en & ((level[i]==MAX) | (level[i] > pwm_cnt)).
  - Level 0 gives constant 0.
  - Level MAX gives constant 1.
  - Level L gives L high cycles per 2^PWM_BITS-cycle PWM period.
- busy is registered: the OR over channels of (state==RISING or state==FALLING).
- Latency from a led_in edge:
  - led_in_q follows after 1 clk.
  - The state change appears 1 clk after led_in_q changes.
  - The first level change happens on the next step_tick, within STEP_DIV clks of led_in_q changing.
- Simultaneous events: if led_in changes in the same cycle as step_tick, that step uses the old led_in_q.
- en deasserted mid-fade:
  - Levels and states freeze.
  - led_out = 0 from the next clk.
  - busy keeps its value.
  - On re-enable, the fade resumes from the frozen level, with prescaler and pwm_cnt restarting from 0.
- rst asserted mid-fade: all outputs go to 0 immediately. After release, every channel starts from OFF at level 0.

Test Plan:
Benches use PWM_BITS=4 (MAX=15) and STEP_DIV=4 unless stated otherwise.
1. Async reset: drive led_in=3'b111 for 30 cycles, then pull rst low between clock edges -> led_out=3'b000 and busy=0 before the next edge; after release, all levels are 0.
2. Fade-in: led_in=3'b001 held -> busy rises within 2 clks; ch0 level reaches 15 after 15 step_ticks (about 60 clks plus latency); ch0 state goes to ON; busy drops; led_out[0] is constant 1 thereafter; led_out[2:1] stay 0.
3. PWM duty (STEP_DIV=16): during a fade-in, each 16-cycle PWM window aligned to a step shows exactly L high cycles on led_out[0] for level L=1..14.
4. Reversal and saturation: led_in=3'b001 for 6 steps, then 3'b000 -> level 6 -> 0 over 6 steps, state goes RISING -> FALLING -> OFF, no underflow; holding 3'b001 for 40 steps keeps level at 15 with no wrap.
5. Enable freeze: deassert en at level 7 -> led_out=0 from the next clk and level stays 7 for 50 clks; reassert en -> level continues 8, 9, ... on subsequent step_ticks.
6. Sequencer pattern: apply 001 -> 010 -> 100 -> 000, each held 20 steps -> each channel ramps to 15 and back to 0 in turn, adjacent channels cross-fade, and busy=0 only after the final channel reaches OFF.

Source files
------------

// File: rtl/led_fade_driver.sv
// Per-channel LED fader: ramps each channel's brightness toward the sequencer's
// on/off target one step per prescaler tick and drives the pins through PWM.
module led_fade_driver #(
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 196000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] led_in,
  output logic [NUM_CH-1:0] led_out,
  output logic              busy
);

  localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RISING,
    CH_ON,
    CH_FALLING
  } ch_state_e;

  // One brightness step toward the target, pinned at 0 and LVL_MAX.
  function automatic logic [PWM_BITS-1:0] sat_step(
    input logic [PWM_BITS-1:0] lvl,
    input logic                up
  );
    logic [PWM_BITS-1:0] res;
    res = lvl;
    if (up && (lvl != LVL_MAX)) begin
      res = lvl + PWM_BITS'(1);
    end else if (!up && (lvl != '0)) begin
      res = lvl - PWM_BITS'(1);
    end
    return res;
  endfunction

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]   led_in_q;
  logic [PWM_BITS-1:0] level_q [NUM_CH];
  logic [PWM_BITS-1:0] level_d [NUM_CH];
  ch_state_e           state_q [NUM_CH];
  ch_state_e           state_d [NUM_CH];
  logic [NUM_CH-1:0]   led_out_q, led_out_d;
  logic                busy_q, busy_d;
  logic                step_tick;

  always_comb begin
    step_tick   = en && (prescaler_q == PRE_LAST);
    prescaler_d = '0;
    if (en && !step_tick) begin
      prescaler_d = prescaler_q + PRE_W'(1);
    end
    pwm_cnt_d = en ? (pwm_cnt_q + PWM_BITS'(1)) : '0;
  end

  // State transitions look at the level after this cycle's step, so a ramp that
  // lands on an end point changes state on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      level_d[i] = level_q[i];
      state_d[i] = state_q[i];
      if (step_tick) begin
        level_d[i] = sat_step(level_q[i], led_in_q[i]);
      end
      if (en) begin
        case (state_q[i])
          CH_OFF: begin
            if (led_in_q[i]) state_d[i] = CH_RISING;
          end
          CH_RISING: begin
            if (!led_in_q[i])               state_d[i] = CH_FALLING;
            else if (level_d[i] == LVL_MAX) state_d[i] = CH_ON;
          end
          CH_ON: begin
            if (!led_in_q[i]) state_d[i] = CH_FALLING;
          end
          CH_FALLING: begin
            if (led_in_q[i])              state_d[i] = CH_RISING;
            else if (level_d[i] == '0)    state_d[i] = CH_OFF;
          end
          default: state_d[i] = CH_OFF;
        endcase
      end
    end
  end

  always_comb begin
    led_out_d = '0;
    busy_d    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      led_out_d[i] = en && ((level_q[i] == LVL_MAX) || (level_q[i] > pwm_cnt_q));
      busy_d       = busy_d || (state_d[i] == CH_RISING) || (state_d[i] == CH_FALLING);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q <= '0;
      pwm_cnt_q   <= '0;
      led_in_q    <= '0;
      led_out_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= '0;
        state_q[i] <= CH_OFF;
      end
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_in_q    <= led_in;
      led_out_q   <= led_out_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= level_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver; brightness is observed as high-cycle counts
// over 16-cycle windows that line up with the brightness steps.
module tb_led_fade_driver;

  localparam int NUM_CH   = 3;
  localparam int PWM_BITS = 4;
  localparam int STEP_DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [2:0] led_in = 3'b000;
  logic [2:0] led_out;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_CH  (NUM_CH),
    .PWM_BITS(PWM_BITS),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .led_in (led_in),
    .led_out(led_out),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Steps n clocks, counting high samples per channel and busy samples.
  task automatic measure(input int n, output int c0, output int c1, output int c2,
                         output int bcnt, output logic blast);
    c0 = 0; c1 = 0; c2 = 0; bcnt = 0; blast = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      c0    += (led_out[0] === 1'b1) ? 1 : 0;
      c1    += (led_out[1] === 1'b1) ? 1 : 0;
      c2    += (led_out[2] === 1'b1) ? 1 : 0;
      bcnt  += (busy === 1'b1) ? 1 : 0;
      blast  = busy;
    end
  endtask

  // Releases reset on a falling edge so the next rising edge is cycle 1.
  task automatic apply_reset(input logic [2:0] pat);
    @(negedge clk);
    rst    = 1'b0;
    en     = 1'b1;
    led_in = pat;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int   c0, c1, c2, bc;
    logic bl;

    // Asynchronous reset mid-fade
    apply_reset(3'b111);
    measure(33, c0, c1, c2, bc, bl);
    chk("pre_rst_led_out", led_out, 3'b111);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_led_out", led_out, 3'b000);
    chk("async_rst_busy", busy, 0);

    // Fade-in on channel 0: window w shows w high cycles
    apply_reset(3'b001);
    for (int w = 0; w < 16; w++) begin
      measure(16, c0, c1, c2, bc, bl);
      chk($sformatf("fadein_duty_w%0d", w), c0, (w == 15) ? 16 : w);
      chk($sformatf("fadein_other_w%0d", w), c1 + c2, 0);
      if (w == 0)  chk("fadein_busy_w0", bl, 1);
      if (w == 13) chk("fadein_busy_w13", bl, 1);
      if (w == 14) chk("fadein_busy_done", bl, 0);
      if (w == 15) chk("fadein_busy_idle", bc, 0);
    end

    // Reversal after 6 steps, underflow guard, then saturation
    apply_reset(3'b001);
    for (int w = 0; w < 6; w++) measure(16, c0, c1, c2, bc, bl);
    led_in = 3'b000;
    for (int w = 6; w < 13; w++) begin
      measure(16, c0, c1, c2, bc, bl);
      chk($sformatf("reverse_duty_w%0d", w), c0, 12 - w);
      if (w == 6)  chk("reverse_busy_w6", bl, 1);
      if (w == 10) chk("reverse_busy_w10", bl, 1);
      if (w == 11) chk("reverse_busy_off", bl, 0);
    end
    measure(16, c0, c1, c2, bc, bl);
    chk("no_underflow_duty", c0, 0);
    chk("no_underflow_busy", bc, 0);
    led_in = 3'b001;
    for (int w = 0; w < 40; w++) measure(16, c0, c1, c2, bc, bl);
    chk("saturate_duty", c0, 16);
    chk("saturate_busy", bc, 0);

    // Enable freeze at level 7
    apply_reset(3'b001);
    for (int w = 0; w < 7; w++) measure(16, c0, c1, c2, bc, bl);
    en = 1'b0;
    measure(50, c0, c1, c2, bc, bl);
    chk("freeze_blank", c0 + c1 + c2, 0);
    chk("freeze_busy_held", bc, 50);
    en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      measure(16, c0, c1, c2, bc, bl);
      chk($sformatf("resume_duty_%0d", w), c0, 7 + w);
    end

    // Sequencer pattern 001 -> 010 -> 100 -> 000, 20 steps each
    apply_reset(3'b001);
    for (int w = 0; w < 80; w++) begin
      if (w == 20) led_in = 3'b010;
      if (w == 40) led_in = 3'b100;
      if (w == 60) led_in = 3'b000;
      measure(16, c0, c1, c2, bc, bl);
      case (w)
        21: begin
          chk("xfade_w21_ch0", c0, 14);
          chk("xfade_w21_ch1", c1, 1);
          chk("xfade_w21_ch2", c2, 0);
        end
        28: begin
          chk("xfade_w28_ch0", c0, 7);
          chk("xfade_w28_ch1", c1, 8);
        end
        41: begin
          chk("xfade_w41_ch0", c0, 0);
          chk("xfade_w41_ch1", c1, 14);
          chk("xfade_w41_ch2", c2, 1);
        end
        59: chk("seq_busy_w59", bl, 0);
        61: chk("fadeout_w61_ch2", c2, 14);
        73: chk("seq_busy_w73", bl, 1);
        74: begin
          chk("fadeout_w74_ch2", c2, 1);
          chk("seq_busy_w74", bl, 0);
        end
        75: chk("seq_all_dark", c0 + c1 + c2, 0);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
